// File: rtl/comb_row_buffer.sv
// comb_row_buffer
// Result row store at the output of the Combination Block and responder for
// the Argmax read interface. A producer writes FEATURE_ROWS rows in order
// over a valid/ready handshake; once the last row lands done_comb is held
// high. The consumer drives read_row and samples adj_fm_wm_row in the same
// cycle (combinational read).
//
// Ports:
//   clk           - clock, all state on rising edge
//   reset         - synchronous, active-high reset (clears state and storage)
//   start         - one-cycle pulse, arms (or re-arms) a fill from row 0
//   wr_valid      - producer has a row on wr_row
//   wr_row        - row data, WEIGHT_COLS elements of DOT_PROD_WIDTH bits
//   wr_ready      - buffer accepts a row this cycle (high only while filling)
//   rows_written  - rows accepted since the last start
//   done_comb     - all FEATURE_ROWS rows stored (level)
//   read_row      - consumer row address
//   adj_fm_wm_row - stored row at read_row, all zeros when out of range
//   rd_err        - registered out-of-range / unwritten-row read flag
//
// Optional feature: define COMB_BUF_RD_CHECK_EN to enable rd_err checking;
// otherwise rd_err is tied low and no check logic exists.

module comb_row_buffer #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      wr_valid,
  input  logic [DOT_PROD_WIDTH-1:0] wr_row [0:WEIGHT_COLS-1],
  output logic                      wr_ready,
  output logic [FEATURE_WIDTH:0]    rows_written,
  output logic                      done_comb,
  input  logic [FEATURE_WIDTH-1:0]  read_row,
  output logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_row [0:WEIGHT_COLS-1],
  output logic                      rd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [FEATURE_WIDTH:0]   LP_ROWS = (FEATURE_WIDTH+1)'(FEATURE_ROWS);
  localparam logic [FEATURE_WIDTH-1:0] LP_LAST = FEATURE_WIDTH'(FEATURE_ROWS - 1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [FEATURE_WIDTH-1:0]  r_wr_ptr;
  logic [FEATURE_WIDTH:0]    r_rows_written;
  logic [DOT_PROD_WIDTH-1:0] r_mem [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
  logic                      w_wr_ready;
  logic                      w_done;
  logic                      w_wr_en;
  logic                      w_rd_in_range;

  // Next-state and handshake decode. start has priority over a handshake in
  // the same cycle, so a colliding row is dropped.
  always_comb begin
    w_next_state = r_state;
    w_wr_ready   = 1'b0;
    w_done       = 1'b0;
    w_wr_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next_state = FILL;
      end
      FILL: begin
        w_wr_ready = 1'b1;
        if (!start && wr_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == LP_LAST) w_next_state = FULL;
        end
      end
      FULL: begin
        w_done = 1'b1;
        if (start) w_next_state = FILL;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_rows_written <= '0;
      for (int unsigned r = 0; r < FEATURE_ROWS; r++) begin
        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else begin
      r_state <= w_next_state;
      if (start) begin
        r_wr_ptr       <= '0;
        r_rows_written <= '0;
      end else if (w_wr_en) begin
        for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
          r_mem[r_wr_ptr][c] <= wr_row[c];
        end
        r_wr_ptr       <= r_wr_ptr + FEATURE_WIDTH'(1);
        r_rows_written <= r_rows_written + (FEATURE_WIDTH+1)'(1);
      end
    end
  end

  // Zero-latency read; addresses beyond the depth read as zero.
  assign w_rd_in_range = ({1'b0, read_row} < LP_ROWS);

  always_comb begin
    for (int unsigned c = 0; c < WEIGHT_COLS; c++) begin
      adj_fm_wm_row[c] = '0;
      if (w_rd_in_range) adj_fm_wm_row[c] = r_mem[read_row][c];
    end
  end

`ifdef COMB_BUF_RD_CHECK_EN
  logic r_rd_err;

  // Flags a read past the depth, or of a row not yet written in this fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_err <= 1'b0;
    end else begin
      r_rd_err <= !w_rd_in_range ||
                  ((r_state != FULL) && ({1'b0, read_row} >= r_rows_written));
    end
  end

  assign rd_err = r_rd_err;
`else
  assign rd_err = 1'b0;
`endif

  assign wr_ready     = w_wr_ready;
  assign done_comb    = w_done;
  assign rows_written = r_rows_written;

endmodule

// File: tb/tb_comb_row_buffer.sv
// Scoreboard bench for comb_row_buffer: each driven cycle pushes the expected
// outputs from a behavioural model into a queue; a negedge monitor pops and
// compares against the DUT.

module tb_comb_row_buffer;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int DW   = 16;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_row [0:COLS-1];
  logic          wr_ready;
  logic [AW:0]   rows_written;
  logic          done_comb;
  logic [AW-1:0] read_row = '0;
  logic [DW-1:0] adj_fm_wm_row [0:COLS-1];
  logic          rd_err;

  comb_row_buffer #(
    .FEATURE_ROWS  (ROWS),
    .WEIGHT_COLS   (COLS),
    .DOT_PROD_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .wr_valid     (wr_valid),
    .wr_row       (wr_row),
    .wr_ready     (wr_ready),
    .rows_written (rows_written),
    .done_comb    (done_comb),
    .read_row     (read_row),
    .adj_fm_wm_row(adj_fm_wm_row),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        done;
    logic [3:0]  cnt;
    logic [47:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];

  // Reference model: a plain array of rows plus fill bookkeeping.
  logic [47:0] m_mem [ROWS];
  int          m_cnt = 0;
  bit          m_filling = 0;
  bit          m_full = 0;
  bit          m_err = 0;
  bit          push_en = 0;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  function automatic logic [47:0] mk(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  // Drive one cycle, record what the DUT must show during it, then advance
  // the model to the state the coming clock edge produces.
  task automatic cyc(input bit rst, input bit st, input bit v,
                     input logic [47:0] row, input int rr);
    exp_t e;
    bit   pred;
    @(posedge clk); #1;
    reset    = rst;
    start    = st;
    wr_valid = v;
    for (int c = 0; c < COLS; c++) wr_row[c] = row[16*c +: 16];
    read_row = AW'(rr);
    e.ready = m_filling;
    e.done  = m_full;
    e.cnt   = 4'(m_cnt);
    e.data  = (rr < ROWS) ? m_mem[rr] : 48'h0;
`ifdef COMB_BUF_RD_CHECK_EN
    e.err   = m_err;
`else
    e.err   = 1'b0;
`endif
    if (push_en) sbq.push_back(e);
    pred = (rr >= ROWS) || (!m_full && rr >= m_cnt);
    if (rst) begin
      for (int r = 0; r < ROWS; r++) m_mem[r] = '0;
      m_cnt = 0; m_filling = 0; m_full = 0; m_err = 0;
    end else begin
      m_err = pred;
      if (st) begin
        m_filling = 1; m_full = 0; m_cnt = 0;
      end else if (m_filling && v) begin
        m_mem[m_cnt] = row;
        m_cnt++;
        if (m_cnt == ROWS) begin
          m_filling = 0; m_full = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("wr_ready", 64'(wr_ready), 64'(e.ready));
      chk("done_comb", 64'(done_comb), 64'(e.done));
      chk("rows_written", 64'(rows_written), 64'(e.cnt));
      chk("adj_fm_wm_row", 64'({adj_fm_wm_row[2], adj_fm_wm_row[1], adj_fm_wm_row[0]}), 64'(e.data));
      chk("rd_err", 64'(rd_err), 64'(e.err));
    end
  end

  initial begin
    for (int c = 0; c < COLS; c++) wr_row[c] = '0;
    for (int r = 0; r < ROWS; r++) m_mem[r] = '0;

    // First reset cycle leaves unknowns behind it; check from the second on.
    cyc(1, 0, 0, '0, 0);
    push_en = 1;
    cyc(1, 0, 0, '0, 0);
    // Writes in IDLE are ignored.
    cyc(0, 0, 1, mk(99, 99, 99), 0);
    cyc(0, 0, 1, mk(98, 98, 98), 7);

    // Basic back-to-back fill.
    cyc(0, 1, 0, '0, 0);
    for (int i = 0; i < ROWS; i++) cyc(0, 0, 1, mk(10*i, 10*i+1, 10*i+2), i);
    cyc(0, 0, 0, '0, 3);
    cyc(0, 0, 1, mk(55, 55, 55), 7);  // write in FULL ignored; out-of-range read
    cyc(0, 0, 0, '0, 5);

    // Restart with one row.
    cyc(0, 1, 0, '0, 0);
    cyc(0, 0, 1, mk(7, 7, 7), 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 2);

    // Gapped fill.
    cyc(0, 1, 0, '0, 0);
    for (int i = 0; i < 2*ROWS; i++) cyc(0, 0, (i % 2 == 0), mk(100+i, 200+i, 300+i), i % 8);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, '0, i);

    // Collision: start with wr_valid after 3 rows.
    cyc(0, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, mk(40+i, 41+i, 42+i), i);
    cyc(0, 1, 1, mk(66, 66, 66), 0);
    cyc(0, 0, 1, mk(77, 78, 79), 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 2);

    // Fill then out-of-range read, and unwritten read mid-fill.
    for (int i = 1; i < ROWS; i++) cyc(0, 0, 1, mk(i, i, i), 7);
    cyc(0, 0, 0, '0, 7);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 0, 1, mk(1, 2, 3), 0);
    cyc(0, 0, 1, mk(4, 5, 6), 0);
    cyc(0, 0, 0, '0, 2);
    cyc(0, 0, 0, '0, 1);

    // Reset mid-fill.
    cyc(0, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, mk(500+i, 600+i, 700+i), i);
    cyc(1, 0, 0, '0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, mk(9, 9, 9), i);
    cyc(0, 1, 0, '0, 0);
    for (int i = 0; i < ROWS; i++) cyc(0, 0, 1, mk(i+1, i+2, i+3), i);
    cyc(0, 0, 0, '0, 4);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [47:0] rnd;
      rnd = {16'($urandom), $urandom};
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), rnd, int'($urandom_range(0, 7)));
    end

    cyc(0, 0, 0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
